// File: rtl/pulse_pattern_gen.sv
// Multi-channel pulse pattern generator: a free-running frame timer gates CH
// output lines through WIN programmable windows each, with double-buffered config.
module pulse_pattern_gen #(
    parameter int unsigned CH         = 3,
    parameter int unsigned WIN        = 3,
    parameter int unsigned TW         = 15,
    parameter int unsigned PERIOD_DEF = 15000,
    parameter int unsigned AW         = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          start,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [TW-1:0] cfg_data,
    output logic [CH-1:0] out,
    output logic          frame_start,
    output logic          busy
);

    localparam int unsigned NW = CH * WIN;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic          cont_q, cont_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [TW-1:0] per_sh_q, per_sh_d;
    logic [TW-1:0] per_act_q, per_act_d;
    logic [TW-1:0] s_sh_q  [NW];
    logic [TW-1:0] s_sh_d  [NW];
    logic [TW-1:0] e_sh_q  [NW];
    logic [TW-1:0] e_sh_d  [NW];
    logic [TW-1:0] s_act_q [NW];
    logic [TW-1:0] s_act_d [NW];
    logic [TW-1:0] e_act_q [NW];
    logic [TW-1:0] e_act_d [NW];
    logic [CH-1:0] out_q, out_d;
    logic          fs_q, fs_d;
    logic          busy_q, busy_d;
    logic          load;
    logic          at_end;

    assign at_end = (timer_q == per_act_q);

    // Shadow register file; writes accepted in any state, unmapped addresses dropped
    always_comb begin
        per_sh_d = per_sh_q;
        s_sh_d   = s_sh_q;
        e_sh_d   = e_sh_q;
        if (cfg_we) begin
            if (cfg_addr == '0) per_sh_d = cfg_data;
            for (int unsigned i = 0; i < NW; i++) begin
                if (cfg_addr == AW'(2 * i + 1)) s_sh_d[i] = cfg_data;
                if (cfg_addr == AW'(2 * i + 2)) e_sh_d[i] = cfg_data;
            end
        end
    end

    // Active set copies the pre-write shadow values at frame boundaries
    always_comb begin
        per_act_d = per_act_q;
        s_act_d   = s_act_q;
        e_act_d   = e_act_q;
        if (load) begin
            per_act_d = per_sh_q;
            s_act_d   = s_sh_q;
            e_act_d   = e_sh_q;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cont_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cont_q  <= cont_d;
        end
    end

    // Next-state logic; en wins over start, and a running frame always completes
    always_comb begin
        state_d = state_q;
        cont_d  = cont_q;
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_RUN;
                    cont_d  = 1'b1;
                end else if (start) begin
                    state_d = S_RUN;
                    cont_d  = 1'b0;
                end
            end
            S_RUN: begin
                if (at_end && !(cont_q && en)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: timer advance, active-set load and window compare
    always_comb begin
        timer_d = '0;
        load    = 1'b0;
        out_d   = '0;
        fs_d    = 1'b0;
        busy_d  = (state_d == S_RUN);
        case (state_q)
            S_IDLE: begin
                load = (state_d == S_RUN);
            end
            S_RUN: begin
                if (at_end) begin
                    load = (state_d == S_RUN);
                end else begin
                    timer_d = timer_q + TW'(1);
                end
                fs_d = (timer_q == '0);
                for (int unsigned c = 0; c < CH; c++) begin
                    for (int unsigned w = 0; w < WIN; w++) begin
                        if ((s_act_q[c*WIN+w] <= timer_q) && (timer_q < e_act_q[c*WIN+w]))
                            out_d[c] = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q   <= '0;
            per_sh_q  <= TW'(PERIOD_DEF);
            per_act_q <= TW'(PERIOD_DEF);
            for (int unsigned i = 0; i < NW; i++) begin
                s_sh_q[i]  <= '0;
                e_sh_q[i]  <= '0;
                s_act_q[i] <= '0;
                e_act_q[i] <= '0;
            end
            out_q  <= '0;
            fs_q   <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            per_sh_q  <= per_sh_d;
            per_act_q <= per_act_d;
            s_sh_q    <= s_sh_d;
            e_sh_q    <= e_sh_d;
            s_act_q   <= s_act_d;
            e_act_q   <= e_act_d;
            out_q     <= out_d;
            fs_q      <= fs_d;
            busy_q    <= busy_d;
        end
    end

    assign out         = out_q;
    assign frame_start = fs_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_pulse_pattern_gen.sv
// Bench for pulse_pattern_gen: cycle-level frame model plus per-frame pulse measurements.
module tb_pulse_pattern_gen;

    localparam int CH   = 3;
    localparam int WIN  = 3;
    localparam int TW   = 15;
    localparam int AW   = 8;
    localparam int PDEF = 15000;
    localparam int NW   = CH * WIN;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          start = 1'b0;
    logic          cfg_we = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [TW-1:0] cfg_data = '0;
    logic [CH-1:0] out;
    logic          frame_start;
    logic          busy;

    pulse_pattern_gen #(
        .CH(CH), .WIN(WIN), .TW(TW), .PERIOD_DEF(PDEF), .AW(AW)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .start(start),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .out(out), .frame_start(frame_start), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Model: frame offset, running flag, shadow and active window sets
    int m_per_sh = PDEF;
    int m_per = PDEF;
    int m_s_sh[NW];
    int m_e_sh[NW];
    int m_s[NW];
    int m_e[NW];
    bit m_run = 1'b0;
    bit m_cont = 1'b0;
    int m_t = 0;
    logic [CH-1:0] exp_out = '0;
    logic exp_fs = 1'b0;
    logic exp_busy = 1'b0;

    function automatic logic [CH-1:0] windows_at(input int t);
        logic [CH-1:0] r = '0;
        for (int c = 0; c < CH; c++)
            for (int w = 0; w < WIN; w++)
                if (m_s[c*WIN+w] <= t && t < m_e[c*WIN+w]) r[c] = 1'b1;
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        int a;
        bit do_load;
        if (rst) begin
            m_per_sh = PDEF;
            m_per = PDEF;
            for (int i = 0; i < NW; i++) begin
                m_s_sh[i] = 0; m_e_sh[i] = 0; m_s[i] = 0; m_e[i] = 0;
            end
            m_run = 1'b0; m_cont = 1'b0; m_t = 0;
            exp_out = '0; exp_fs = 1'b0; exp_busy = 1'b0;
        end else begin
            exp_out = m_run ? windows_at(m_t) : '0;
            exp_fs = m_run && (m_t == 0);
            do_load = 1'b0;
            if (!m_run) begin
                if (en || start) begin
                    m_run = 1'b1; m_cont = en; m_t = 0; do_load = 1'b1;
                end
            end else if (m_t == m_per) begin
                m_t = 0;
                if (m_cont && en) do_load = 1'b1;
                else m_run = 1'b0;
            end else begin
                m_t++;
            end
            if (do_load) begin
                m_per = m_per_sh;
                for (int i = 0; i < NW; i++) begin
                    m_s[i] = m_s_sh[i]; m_e[i] = m_e_sh[i];
                end
            end
            exp_busy = m_run;
            if (cfg_we) begin
                a = int'(cfg_addr);
                if (a == 0) m_per_sh = int'(cfg_data);
                else if (a <= 2 * NW) begin
                    if (a % 2 == 1) m_s_sh[(a-1)/2] = int'(cfg_data);
                    else m_e_sh[(a-1)/2] = int'(cfg_data);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("out", 32'(out), 32'(exp_out));
            check("frame_start", 32'(frame_start), 32'(exp_fs));
            check("busy", 32'(busy), 32'(exp_busy));
        end
    end

    // Per-frame measurement: len, then per channel (first high offset, first run width, total)
    logic mon_en = 1'b0;
    int mq[$];
    int mon_off = 0;
    bit mon_started = 1'b0;
    int mf[CH];
    int mr[CH];
    int mt[CH];
    bit min_run[CH];

    always @(negedge clk) begin
        if (!mon_en) begin
            mq.delete();
            mon_started = 1'b0;
        end else begin
            if (frame_start) begin
                if (mon_started) begin
                    mq.push_back(mon_off);
                    for (int c = 0; c < CH; c++) begin
                        mq.push_back(mf[c]); mq.push_back(mr[c]); mq.push_back(mt[c]);
                    end
                end
                mon_started = 1'b1;
                mon_off = 0;
                for (int c = 0; c < CH; c++) begin
                    mf[c] = -1; mr[c] = 0; mt[c] = 0; min_run[c] = 1'b0;
                end
            end
            if (mon_started) begin
                for (int c = 0; c < CH; c++) begin
                    if (out[c]) begin
                        mt[c]++;
                        if (mf[c] < 0) begin
                            mf[c] = mon_off; mr[c] = 1; min_run[c] = 1'b1;
                        end else if (min_run[c]) mr[c]++;
                    end else min_run[c] = 1'b0;
                end
                mon_off++;
            end
        end
    end

    function automatic int ent(input int e, input int k);
        return mq[e*10+k];
    endfunction

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic cfg(input int a, input int d);
        cfg_we = 1'b1; cfg_addr = AW'(a); cfg_data = TW'(d);
        tick;
        cfg_we = 1'b0;
    endtask

    task automatic wait_run_t(input string name, input int t, input int bound);
        int n = 0;
        while (!(m_run && m_t == t) && n < bound) begin tick; n++; end
        check(name, 32'(n < bound), 32'd1);
    endtask

    task automatic wait_q(input string name, input int k, input int bound);
        int n = 0;
        while (mq.size() < k && n < bound) begin tick; n++; end
        check(name, 32'(n < bound), 32'd1);
    endtask

    task automatic check_frame(input string name, input int e, input int c,
                               input int first, input int run, input int total);
        check({name, "_first"}, 32'(ent(e, 1 + 3*c)), 32'(first));
        check({name, "_run"},   32'(ent(e, 2 + 3*c)), 32'(run));
        check({name, "_total"}, 32'(ent(e, 3 + 3*c)), 32'(total));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int o_cnt, b_cnt, f_cnt, n, c2;
        tick;
        check("rst_out", 32'(out), 32'd0);
        check("rst_fs", 32'(frame_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick;

        // One-shot with a second start ignored mid-run
        cfg(0, 99); cfg(1, 10); cfg(2, 20);
        start = 1'b1; tick; start = 1'b0;
        o_cnt = 0; b_cnt = 0; f_cnt = 0;
        for (int i = 0; i < 250; i++) begin
            if (out[0]) o_cnt++;
            if (busy) b_cnt++;
            if (frame_start) f_cnt++;
            start = (i == 50);
            tick;
        end
        check("os_out_width", 32'(o_cnt), 32'd10);
        check("os_busy_cycles", 32'(b_cnt), 32'd100);
        check("os_frames", 32'(f_cnt), 32'd1);

        // Double buffering: mid-frame write, then a write on the wrap cycle
        mon_en = 1'b1; en = 1'b1;
        wait_run_t("db_wait40", 40, 200);
        cfg(1, 30); cfg(2, 50);
        wait_run_t("db_wait99", 99, 200);
        cfg(2, 60); cfg(1, 40);
        wait_q("db_frames", 30, 400);
        check("db_len", 32'(ent(0, 0)), 32'd100);
        check_frame("db_f1", 0, 0, 10, 10, 10);
        check_frame("db_f2", 1, 0, 30, 20, 20);
        check_frame("db_f3", 2, 0, 40, 20, 20);

        // Graceful stop: drop en at timer 5
        wait_run_t("stop_wait5", 5, 200);
        en = 1'b0;
        n = 0;
        while (busy && n < 200) begin n++; tick; end
        check("stop_busy_cycles", 32'(n), 32'd95);
        tick;
        check("stop_out", 32'(out), 32'd0);
        check("stop_busy", 32'(busy), 32'd0);
        mon_en = 1'b0;

        // P=0 one-cycle frames with ch0 (0,1)
        cfg(0, 0); cfg(1, 0); cfg(2, 1);
        en = 1'b1; tick; tick;
        o_cnt = 0; f_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (out[0]) o_cnt++;
            if (frame_start) f_cnt++;
            tick;
        end
        check("p0_out_high", 32'(o_cnt), 32'd20);
        check("p0_frames", 32'(f_cnt), 32'd20);
        en = 1'b0; tick; tick;
        check("p0_stop_busy", 32'(busy), 32'd0);

        // P=9, ch1 (5,20) clipped at frame end, ch2 S=E disabled
        cfg(0, 9); cfg(7, 5); cfg(8, 20); cfg(13, 7); cfg(14, 7);
        mon_en = 1'b1; en = 1'b1;
        n = 0; c2 = 0;
        while (mq.size() < 20 && n < 100) begin
            if (out[2]) c2++;
            n++; tick;
        end
        check("edge_frames", 32'(n < 100), 32'd1);
        check("edge_ch2_high", 32'(c2), 32'd0);
        check("edge_len", 32'(ent(1, 0)), 32'd10);
        check_frame("edge_ch1_f0", 0, 1, 5, 5, 5);
        check_frame("edge_ch1_f1", 1, 1, 5, 5, 5);
        check_frame("edge_ch0_f1", 1, 0, 0, 1, 1);

        // Reset mid-frame: shadow P=200 must be lost
        cfg(0, 200);
        wait_run_t("rst_wait50", 50, 400);
        rst = 1'b1; en = 1'b0; mon_en = 1'b0;
        #1;
        check("arst_out", 32'(out), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_fs", 32'(frame_start), 32'd0);
        tick; tick;
        rst = 1'b0;
        tick;

        // Legacy pattern on the default period
        cfg(1, 0);    cfg(2, 14);   cfg(3, 406);  cfg(4, 507);  cfg(5, 1856); cfg(6, 3057);
        cfg(7, 21);   cfg(8, 35);   cfg(9, 424);  cfg(10, 529); cfg(11, 1876); cfg(12, 3089);
        cfg(13, 0);   cfg(14, 51);
        mon_en = 1'b1; en = 1'b1;
        wait_q("leg_frames", 10, 16000);
        check("leg_len", 32'(ent(0, 0)), 32'd15001);
        check_frame("leg_ch0", 0, 0, 0, 14, 1316);
        check_frame("leg_ch1", 0, 1, 21, 14, 1332);
        check_frame("leg_ch2", 0, 2, 0, 51, 51);
        en = 1'b0;
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
